frame_writer: RTL
=================

# frame_writer

Producer side of the 80x60 display frame buffer. Accepts a stream of 16-bit samples over a valid/ready handshake and writes them in raster order into the frame-buffer memory as words 0..4799. It then pulses the display block's start input and waits for that block's end-of-frame indication before accepting the next frame. Sits between the sample source (DSP/sensor path) and the frame-buffer SRAM that the VGA display block reads.

## Interface
- PIXEL_COLUMN, 80, pixels per row
- PIXEL_ROW, 60, rows per frame
- DATA_W, 16, sample width
- ADDR_W, 20, frame-buffer address width
- i_clk_25M  in  1  single clock for the whole block
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  level/pulse; arms capture of one frame when idle
- i_data  in  DATA_W  sample
- i_valid  in  1  sample valid
- o_ready  out  1  block can accept a sample this cycle
- o_wr_en  out  1  memory write strobe
- o_wr_address  out  ADDR_W  memory word address
- o_wr_data  out  DATA_W  memory write data
- o_start_display  out  1  one-cycle pulse to the display block's start input
- i_display_finish  in  1  display block's end-of-frame pulse
- o_busy  out  1  high whenever state is not S_IDLE
- o_frame_done  out  1  one-cycle pulse when the handed-off frame has been displayed

## Operation
- States: S_IDLE, S_WRITE, S_HANDOFF, S_WAIT_DISPLAY.
- S_IDLE: o_ready=0. i_start=1 -> S_WRITE; col/row counters cleared to 0.
- S_WRITE: o_ready=1. Accept = i_valid & o_ready. On accept: register i_data and address row*PIXEL_COLUMN+col; advance col; at col==PIXEL_COLUMN-1 col wraps to 0 and row increments. On accept of the last pixel (row==PIXEL_ROW-1, col==PIXEL_COLUMN-1) -> S_HANDOFF; o_ready drops the next cycle.
- i_valid=0 in S_WRITE: no write, counters hold; gaps of any length allowed.
- S_HANDOFF: one cycle, o_start_display=1 -> S_WAIT_DISPLAY.
- S_WAIT_DISPLAY: o_ready=0; i_display_finish=1 -> o_frame_done pulse, -> S_IDLE.
- i_start outside S_IDLE is ignored (no queuing). i_display_finish outside S_WAIT_DISPLAY is ignored.
- Address arithmetic: row*PIXEL_COLUMN computed zero-extended to ADDR_W; row, col sized $clog2 of their ranges. Max address 4799; no wrap beyond.
- Samples are written unmodified; color mapping stays in the display block.

## Timing
- Reset values: o_ready=0, o_wr_en=0, o_wr_address=0, o_wr_data=0, o_start_display=0, o_busy=0, o_frame_done=0; state S_IDLE; counters 0.
- Write latency: accept in cycle N -> o_wr_en=1 with matching address/data in cycle N+1, for exactly one cycle. Back-to-back accepts give back-to-back writes.
- o_wr_address/o_wr_data hold last written value while o_wr_en=0.
- o_start_display asserts the cycle after the final write strobe is driven (final write in N+1, pulse in N+2); memory is therefore complete before the display starts.
- o_frame_done asserts the cycle after i_display_finish is sampled.
- Reset mid-frame: next cycle all outputs at reset values, partial frame abandoned, no o_start_display; a pending write strobe is dropped.
- Minimum frame time: 4800 cycles plus 3 overhead, plus display time.

## Configuration
- FRAME_WRITER_MINMAX_EN defined: adds outputs o_frame_min and o_frame_max (DATA_W, reset 16'hFFFF and 0). They are updated per accepted sample with unsigned compare. They are re-initialised on the S_IDLE->S_WRITE transition and are stable from o_start_display onward, so the display block can rescale.
- Undefined: ports and comparators absent; behaviour otherwise identical.

## Structure
- Shared package frame_pkg: PIXEL_COLUMN, PIXEL_ROW, FRAME_WORDS (=4800), state enum type, DATA_W/ADDR_W defaults. The display block uses the same constants.
- One natural sub-module: raster_addr_gen (col/row counters plus address computation, increment enable in, last-pixel flag out). The FSM and write register stay in frame_writer.

## Test plan
- Reset, i_start pulse, 4800 samples i_data=index with i_valid held high -> 4800 consecutive o_wr_en strobes, address k carries data k. o_start_display fires 1 cycle after the strobe at address 4799.
- i_valid toggled 1-0-1 randomly across a frame -> writes only on accepts, addresses still 0..4799 contiguous, no duplicates.
- Check row wrap: accept 81 samples -> 81st write at address 80 with col=0, row=1.
- Assert i_start during S_WRITE and i_display_finish during S_WRITE -> no effect. In S_WAIT_DISPLAY, i_display_finish -> o_frame_done 1 cycle later, o_busy=0.
- i_rst asserted after 2000 accepts -> next cycle all outputs 0, state idle. A new frame after i_start restarts at address 0.
- With FRAME_WRITER_MINMAX_EN: samples include 0x0003 and 0xFFF0 as extremes -> o_frame_min=0x0003, o_frame_max=0xFFF0 at o_start_display.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared frame-buffer constants and types for the 80x60 display path.
// The display block imports the same package, so geometry lives here only.
package frame_pkg;

    localparam int unsigned PIXEL_COLUMN = 80;
    localparam int unsigned PIXEL_ROW    = 60;
    localparam int unsigned FRAME_WORDS  = PIXEL_COLUMN * PIXEL_ROW;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned ADDR_W       = 20;
    localparam int unsigned COL_W        = $clog2(PIXEL_COLUMN);
    localparam int unsigned ROW_W        = $clog2(PIXEL_ROW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_HANDOFF,
        S_WAIT_DISPLAY
    } state_t;

    // Raster word address; the row product is formed at full address width.
    function automatic logic [ADDR_W-1:0] raster_addr(input logic [ROW_W-1:0] row,
                                                      input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(PIXEL_COLUMN) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Column/row counters for raster-order frame writes, with the derived word
// address and a flag marking the final pixel of the frame.
module raster_addr_gen
    import frame_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_last;
    logic             row_last;

    assign col_last = (col_q == COL_W'(PIXEL_COLUMN - 1));
    assign row_last = (row_q == ROW_W'(PIXEL_ROW - 1));
    assign last_o   = col_last & row_last;
    assign addr_o   = raster_addr(row_q, col_q);

    // Next-state counters: clear wins, otherwise advance one pixel per increment.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            if (col_last) begin
                col_d = '0;
                // Wrap rather than run past the frame; a new frame clears anyway.
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counter state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/frame_writer.sv
// Producer side of the frame buffer: takes a valid/ready sample stream, writes
// one full frame in raster order, hands off to the display and waits for it.
// Optional per-frame min/max tracking is enabled by FRAME_WRITER_MINMAX_EN.
module frame_writer
    import frame_pkg::*;
(
    input  logic              i_clk_25M,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_address,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_start_display,
    input  logic              i_display_finish,
    output logic              o_busy,
    output logic              o_frame_done
`ifdef FRAME_WRITER_MINMAX_EN
    ,
    output logic [DATA_W-1:0] o_frame_min,
    output logic [DATA_W-1:0] o_frame_max
`endif
);

    state_t            state_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              start_disp_q;
    logic              frame_done_q;

    logic              accept;
    logic              arm;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_last;

    assign accept = i_valid & (state_q == S_WRITE);
    assign arm    = i_start & (state_q == S_IDLE);

    raster_addr_gen u_raster_addr_gen (
        .clk_i   (i_clk_25M),
        .rst_i   (i_rst),
        .clear_i (arm),
        .inc_i   (accept),
        .addr_o  (pix_addr),
        .last_o  (pix_last)
    );

    // Frame FSM plus registered write port and handshake pulses.
    always_ff @(posedge i_clk_25M) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            start_disp_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            start_disp_q <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= pix_addr;
                        wr_data_q <= i_data;
                        if (pix_last) state_q <= S_HANDOFF;
                    end
                end
                S_HANDOFF: begin
                    // Pulse lands one cycle after the final write strobe.
                    start_disp_q <= 1'b1;
                    state_q      <= S_WAIT_DISPLAY;
                end
                S_WAIT_DISPLAY: begin
                    if (i_display_finish) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready         = (state_q == S_WRITE);
    assign o_busy          = (state_q != S_IDLE);
    assign o_wr_en         = wr_en_q;
    assign o_wr_address    = wr_addr_q;
    assign o_wr_data       = wr_data_q;
    assign o_start_display = start_disp_q;
    assign o_frame_done    = frame_done_q;

`ifdef FRAME_WRITER_MINMAX_EN
    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] max_q;

    // Running unsigned extremes of the current frame; frozen once writing ends.
    always_ff @(posedge i_clk_25M) begin
        if (i_rst || arm) begin
            min_q <= '1;
            max_q <= '0;
        end else if (accept) begin
            if (i_data < min_q) min_q <= i_data;
            if (i_data > max_q) max_q <= i_data;
        end
    end

    assign o_frame_min = min_q;
    assign o_frame_max = max_q;
`endif

endmodule
